// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter in front of a synchronous single-port data RAM
//
// Purpose: shares one data RAM between the core MEM-stage port and a DMA/debug
// master. One transaction is in flight at a time (IDLE -> ACCESS -> RESP).
// Read data and a one-cycle ack pulse are returned three cycles after the
// request is first seen.
//
// Ports:
//   clk_i, rst_n_i                   clock, asynchronous active-low reset
//   core_req_i/we_i/addr_i/wdata_i/be_i   core request and payload (held until ack)
//   core_rdata_o, core_ack_o         core load data and completion pulse
//   core_stall_o                     core_req_i & ~core_ack_o
//   dma_req_i/we_i/addr_i/wdata_i/be_i    DMA request and payload (held until ack)
//   dma_rdata_o, dma_ack_o           DMA load data and completion pulse
//   ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_rdata_i   RAM port
//
// Configuration: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (core first) with a STARVE_MAX guard for the DMA master.
module dmem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wdata_i,
  input  logic [3:0]      core_be_i,
  output logic [XLEN-1:0] core_rdata_o,
  output logic            core_ack_o,
  output logic            core_stall_o,
  input  logic            dma_req_i,
  input  logic            dma_we_i,
  input  logic [XLEN-1:0] dma_addr_i,
  input  logic [XLEN-1:0] dma_wdata_i,
  input  logic [3:0]      dma_be_i,
  output logic [XLEN-1:0] dma_rdata_o,
  output logic            dma_ack_o,
  output logic            ram_en_o,
  output logic [3:0]      ram_we_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_wdata_o,
  input  logic [XLEN-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_dma_q, gnt_dma_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   core_rdata_q, core_rdata_d;
  logic [XLEN-1:0]   dma_rdata_q, dma_rdata_d;
  logic              core_ack_q, core_ack_d;
  logic              dma_ack_q, dma_ack_d;

  logic              core_elig, dma_elig, pick_dma, grant;
  logic              addr_lsb_unused;

  // A requester still sees its own ack this cycle and drops req in it, so the
  // ack cycle must not count as a fresh request.
  assign core_elig = core_req_i & ~core_ack_q;
  assign dma_elig  = dma_req_i & ~dma_ack_q;
  assign grant     = (state_q == S_IDLE) & (core_elig | dma_elig);

  // Word-aligned RAM: byte offset bits are the requester's business.
  assign addr_lsb_unused = ^{core_addr_i[1:0], dma_addr_i[1:0]};

`ifdef DMEM_ARB_RR_EN
  logic last_dma_q, last_dma_d;

  // Tie goes to whoever did not win last time.
  assign pick_dma = dma_elig & (~core_elig | ~last_dma_q);

  always_comb begin
    last_dma_d = last_dma_q;
    if (grant) last_dma_d = pick_dma;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_dma_q <= 1'b1;
    else          last_dma_q <= last_dma_d;
  end
`else
  logic [3:0] starve_q, starve_d;

  // Core wins ties until it has been granted STARVE_MAX times in a row over a
  // waiting DMA request.
  assign pick_dma = dma_elig & (~core_elig | (starve_q == 4'(STARVE_MAX)));

  always_comb begin
    starve_d = starve_q;
    if ((grant & pick_dma) | ~dma_req_i)
      starve_d = '0;
    else if (grant && (starve_q != 4'(STARVE_MAX)))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    gnt_dma_d    = gnt_dma_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    core_ack_d   = 1'b0;
    dma_ack_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          gnt_dma_d = pick_dma;
          if (pick_dma) begin
            we_d    = dma_we_i;
            addr_d  = {dma_addr_i[XLEN-1:2], 2'b00};
            wdata_d = dma_wdata_i;
            be_d    = dma_be_i;
          end else begin
            we_d    = core_we_i;
            addr_d  = {core_addr_i[XLEN-1:2], 2'b00};
            wdata_d = core_wdata_i;
            be_d    = core_be_i;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        // RAM data is valid now; stores leave the requester's rdata untouched.
        if (!we_q) begin
          if (gnt_dma_q) dma_rdata_d  = ram_rdata_i;
          else           core_rdata_d = ram_rdata_i;
        end
        dma_ack_d  = gnt_dma_q;
        core_ack_d = ~gnt_dma_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      gnt_dma_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
      core_ack_q   <= 1'b0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_dma_q    <= gnt_dma_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      core_ack_q   <= core_ack_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

  assign ram_en_o     = (state_q == S_ACCESS);
  assign ram_we_o     = ((state_q == S_ACCESS) && we_q) ? be_q : 4'b0000;
  assign ram_addr_o   = addr_q;
  assign ram_wdata_o  = wdata_q;
  assign core_rdata_o = core_rdata_q;
  assign dma_rdata_o  = dma_rdata_q;
  assign core_ack_o   = core_ack_q;
  assign dma_ack_o    = dma_ack_q;
  assign core_stall_o = core_req_i & ~core_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            core_req, core_we, dma_req, dma_we;
  logic [31:0]     core_addr, core_wdata, dma_addr, dma_wdata;
  logic [3:0]      core_be, dma_be;
  logic [31:0]     core_rdata_o, dma_rdata_o, ram_addr_o, ram_wdata_o;
  logic [31:0]     ram_rdata;
  logic            core_ack_o, dma_ack_o, core_stall_o, ram_en_o;
  logic [3:0]      ram_we_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dmem_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_be_i(core_be),
    .core_rdata_o(core_rdata_o), .core_ack_o(core_ack_o), .core_stall_o(core_stall_o),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_be_i(dma_be),
    .dma_rdata_o(dma_rdata_o), .dma_ack_o(dma_ack_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_9BDF ^ (i * 32'h0101_0111);
  endfunction

  // 16-word synchronous RAM; contents return to a known pattern on reset.
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else if (ram_en_o) begin
      ram_rdata <= ram[ram_addr_o[5:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) ram[ram_addr_o[5:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard queues ----------------
  typedef struct { int cyc; bit who; bit we; logic [31:0] data; } ack_t;
  typedef struct { int cyc; logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } acc_t;
  ack_t ack_q[$];
  acc_t acc_q[$];

  logic [31:0] ref_mem [16];
  int          free_at = 0, exp_ack_c = -1, exp_ack_d = -1, starve = 0;
  bit          last_dma = 1'b1;
  bit          pend_w = 1'b0;
  int          pend_cyc, pend_idx;
  logic [31:0] pend_data;
  logic [3:0]  pend_be;

  initial forever begin : model
    bit ec, ed, pick_d, granted, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    ack_t ae;
    acc_t ce;
    @(negedge clk);
    if (!rst_n) begin
      free_at = 0; exp_ack_c = -1; exp_ack_d = -1; starve = 0;
      last_dma = 1'b1; pend_w = 1'b0;
      ack_q.delete(); acc_q.delete();
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    end else begin
      if (pend_w && cyc == pend_cyc) begin
        for (int b = 0; b < 4; b++)
          if (pend_be[b]) ref_mem[pend_idx][8*b +: 8] = pend_data[8*b +: 8];
        pend_w = 1'b0;
      end
      ec = core_req && (cyc != exp_ack_c);
      ed = dma_req && (cyc != exp_ack_d);
      granted = 1'b0;
      pick_d  = 1'b0;
      if (cyc >= free_at && (ec || ed)) begin
`ifdef DMEM_ARB_RR_EN
        pick_d = ed && (!ec || !last_dma);
`else
        pick_d = ed && (!ec || starve == STARVE_MAX);
`endif
        m_we    = pick_d ? dma_we    : core_we;
        m_addr  = pick_d ? dma_addr  : core_addr;
        m_wdata = pick_d ? dma_wdata : core_wdata;
        m_be    = pick_d ? dma_be    : core_be;
        ce.cyc = cyc + 1; ce.addr = {m_addr[31:2], 2'b00};
        ce.we = m_we ? m_be : 4'b0000; ce.wdata = m_wdata;
        acc_q.push_back(ce);
        ae.cyc = cyc + 3; ae.who = pick_d; ae.we = m_we; ae.data = ref_mem[m_addr[5:2]];
        ack_q.push_back(ae);
        if (m_we) begin
          pend_w = 1'b1; pend_cyc = cyc + 1; pend_idx = int'(m_addr[5:2]);
          pend_data = m_wdata; pend_be = m_be;
        end
        if (pick_d) exp_ack_d = cyc + 3; else exp_ack_c = cyc + 3;
        free_at  = cyc + 3;
        last_dma = pick_d;
        granted  = 1'b1;
      end
      if ((granted && pick_d) || !dma_req) starve = 0;
      else if (granted) starve++;
    end
  end

  initial forever begin : monitor
    ack_t ae;
    acc_t ce;
    bit   core_ack_exp;
    @(negedge clk);
    if (rst_n) begin
      if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
        ce = acc_q.pop_front();
        chk("ram_en", ram_en_o, 1);
        chk("ram_addr", ram_addr_o, ce.addr);
        chk("ram_we", ram_we_o, ce.we);
        chk("ram_wdata", ram_wdata_o, ce.wdata);
      end else begin
        chk("ram_en_idle", ram_en_o, 0);
        chk("ram_we_idle", ram_we_o, 0);
      end
      core_ack_exp = 1'b0;
      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        ae = ack_q.pop_front();
        core_ack_exp = !ae.who;
        chk("core_ack", core_ack_o, !ae.who);
        chk("dma_ack", dma_ack_o, ae.who);
        if (!ae.we && !ae.who) chk("core_rdata", core_rdata_o, ae.data);
        if (!ae.we && ae.who)  chk("dma_rdata", dma_rdata_o, ae.data);
      end else begin
        chk("core_ack_idle", core_ack_o, 0);
        chk("dma_ack_idle", dma_ack_o, 0);
      end
      chk("core_stall", core_stall_o, core_req & ~core_ack_exp);
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input int pct);
    @(posedge clk); #1;
    if (core_req && core_ack_o) core_req = 1'b0;
    else if (!core_req && $urandom_range(99) < pct) begin
      core_we = 1'($urandom_range(1)); core_addr = $urandom; core_wdata = $urandom;
      core_be = 4'($urandom_range(15)); core_req = 1'b1;
    end
    if (dma_req && dma_ack_o) dma_req = 1'b0;
    else if (!dma_req && $urandom_range(99) < pct) begin
      dma_we = 1'($urandom_range(1)); dma_addr = $urandom; dma_wdata = $urandom;
      dma_be = 4'($urandom_range(15)); dma_req = 1'b1;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((core_req || dma_req) && k < 40) begin
      step(0);
      k++;
    end
    chk("drain_timeout", {30'b0, core_req, dma_req}, 0);
  endtask

  task automatic issue_core(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    core_we = we; core_addr = a; core_wdata = d; core_be = be; core_req = 1'b1;
  endtask

  task automatic issue_dma(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    dma_we = we; dma_addr = a; dma_wdata = d; dma_be = be; dma_req = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int k;
    rst_n = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
    dma_req = 0;  dma_we = 0;  dma_addr = 0;  dma_wdata = 0;  dma_be = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_en", ram_en_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_ram_wdata", ram_wdata_o, 0);
    chk("rst_core_ack", core_ack_o, 0);
    chk("rst_dma_ack", dma_ack_o, 0);
    chk("rst_core_rdata", core_rdata_o, 0);
    chk("rst_dma_rdata", dma_rdata_o, 0);
    chk("rst_stall", core_stall_o, 0);
    rst_n = 1'b1;

    // core store then load of 0xDEADBEEF at 0x100
    step(0);
    issue_core(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111); drain();
    issue_core(1'b0, 32'h100, 32'h0, 4'b0000);         drain();
    // partial store to unaligned address, then readback
    issue_core(1'b1, 32'h106, 32'hABCD_0000, 4'b1100); drain();
    issue_core(1'b0, 32'h104, 32'h0, 4'b0000);         drain();
    // simultaneous loads
    issue_core(1'b0, 32'h200, 32'h0, 4'b0000);
    issue_dma(1'b0, 32'h300, 32'h0, 4'b0000);          drain();
    // store with no byte enables leaves memory unchanged
    issue_dma(1'b1, 32'h108, 32'hFFFF_FFFF, 4'b0000);  drain();
    issue_dma(1'b0, 32'h108, 32'h0, 4'b0000);          drain();

    // reset during ACCESS of a DMA store
    issue_dma(1'b1, 32'h10C, 32'h1234_5678, 4'b1111);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ram_en_o && k < 6);
    chk("t5_access_seen", ram_en_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_ram_en", ram_en_o, 0);
    chk("t5_ram_we", ram_we_o, 0);
    chk("t5_ram_addr", ram_addr_o, 0);
    chk("t5_dma_ack", dma_ack_o, 0);
    chk("t5_dma_rdata", dma_rdata_o, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_no_ack", dma_ack_o, 0);
    end
    rst_n = 1'b1;
    drain();
    issue_dma(1'b0, 32'h10C, 32'h0, 4'b0000); drain();

    // both masters continuously requesting
    for (int i = 0; i < 60; i++) step(100);
    drain();
    // random traffic
    for (int i = 0; i < 1500; i++) step(30);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("ack_queue_empty", ack_q.size(), 0);
    chk("acc_queue_empty", acc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
